// File: rtl/gray_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : gray_position_tracker
// Description : Converts a stream of W-bit gray codes to binary. Each new code
//               is classified against the previous one as hold, +1 step,
//               -1 step or an illegal jump. The block keeps a signed running
//               position, the direction of the last step and a saturating
//               count of illegal jumps.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W   gray/binary code width (>= 2)
//   PW  position accumulator width (two's complement)
//   EW  error counter width
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   g        in   W   gray code input
//   g_valid  in   1   g is sampled on an edge only when high
//   b        out  W   binary equivalent of the last decoded code
//   o_valid  out  1   pulse: b/step/dir/err/pos reflect a new sample
//   step     out  1   pulse: the sample was a legal +/-1 move
//   dir      out  1   direction of the last legal step (1 = up), held
//   err      out  1   pulse: illegal jump detected
//   pos      out  PW  signed accumulated position (wraps modulo 2^PW)
//   err_cnt  out  EW  count of illegal jumps, saturates at all-ones
// ============================================================================
module gray_position_tracker #(
  parameter int W  = 3,
  parameter int PW = 8,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  g,
  input  logic          g_valid,
  output logic [W-1:0]  b,
  output logic          o_valid,
  output logic          step,
  output logic          dir,
  output logic          err,
  output logic [PW-1:0] pos,
  output logic [EW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  localparam logic [W-1:0]  C_D_UP   = W'(1);
  localparam logic [W-1:0]  C_D_DN   = '1;
  localparam logic [W-1:0]  C_D_HOLD = '0;
  localparam logic [EW-1:0] C_CNT_MAX = '1;

  // Stage 1: input register
  logic [W-1:0]  r_g;
  logic          r_v;

  // Stage 2 / output registers
  state_t        r_state;
  logic [W-1:0]  r_b;          // also serves as the reference for the next delta
  logic          r_o_valid;
  logic          r_step;
  logic          r_dir;
  logic          r_err;
  logic [PW-1:0] r_pos;
  logic [EW-1:0] r_err_cnt;

  // Next-state values
  state_t        w_state_nxt;
  logic [W-1:0]  w_b_nxt;
  logic          w_o_valid_nxt;
  logic          w_step_nxt;
  logic          w_dir_nxt;
  logic          w_err_nxt;
  logic [PW-1:0] w_pos_nxt;
  logic [EW-1:0] w_err_cnt_nxt;

  logic [W-1:0]  w_bn;
  logic [W-1:0]  w_d;

  // --------------------------------------------------------------------------
  // Stage 1: capture the gray code. A sample held here while rst is asserted
  // is dropped, so it never produces a pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g <= '0;
      r_v <= 1'b0;
    end else begin
      r_v <= g_valid;
      if (g_valid) begin
        r_g <= g;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Gray to binary: each binary bit is the XOR of the gray bits at and above
  // its position. Written as a reduction per bit so no bit depends on
  // another bit of the same vector.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < W; gi++) begin : g_decode
    assign w_bn[gi] = ^(r_g >> gi);
  end

  // Modulo-2^W difference against the previously decoded code
  assign w_d = w_bn - r_b;

  // --------------------------------------------------------------------------
  // State / output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_b       <= '0;
      r_o_valid <= 1'b0;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_pos     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_b       <= w_b_nxt;
      r_o_valid <= w_o_valid_nxt;
      r_step    <= w_step_nxt;
      r_dir     <= w_dir_nxt;
      r_err     <= w_err_nxt;
      r_pos     <= w_pos_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic. Without a valid sample everything holds and
  // the pulse outputs fall.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_b_nxt       = r_b;
    w_o_valid_nxt = 1'b0;
    w_step_nxt    = 1'b0;
    w_dir_nxt     = r_dir;
    w_err_nxt     = 1'b0;
    w_pos_nxt     = r_pos;
    w_err_cnt_nxt = r_err_cnt;

    if (r_v) begin
      // Every valid sample refreshes the reference, whatever its class
      w_o_valid_nxt = 1'b1;
      w_b_nxt       = w_bn;

      unique case (r_state)
        S_IDLE, S_RESYNC: begin
          // Reference is unknown or untrusted: load it without judging it
          w_state_nxt = S_TRACK;
        end

        S_TRACK: begin
          if (w_d == C_D_HOLD) begin
            w_state_nxt = S_TRACK;
          end else if (w_d == C_D_UP) begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b1;
            w_pos_nxt  = r_pos + PW'(1);
          end else if (w_d == C_D_DN) begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b0;
            w_pos_nxt  = r_pos - PW'(1);
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RESYNC;
            if (r_err_cnt != C_CNT_MAX) begin
              w_err_cnt_nxt = r_err_cnt + EW'(1);
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign b       = r_b;
  assign o_valid = r_o_valid;
  assign step    = r_step;
  assign dir     = r_dir;
  assign err     = r_err;
  assign pos     = r_pos;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_position_tracker
// Description : Directed self-checking bench for gray_position_tracker. A
//               second instance with a 2-bit error counter shares the same
//               stimulus and is observed for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_position_tracker;

  logic       clk;
  logic       rst;
  logic [2:0] g;
  logic       g_valid;

  logic [2:0] b;
  logic       o_valid, step, dir, err;
  logic [7:0] pos;
  logic [7:0] err_cnt;

  logic [2:0] s_b;
  logic       s_o_valid, s_step, s_dir, s_err;
  logic [7:0] s_pos;
  logic [1:0] s_err_cnt;

  int n_pass;
  int n_total;

  gray_position_tracker #(.W(3), .PW(8), .EW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .g       (g),
    .g_valid (g_valid),
    .b       (b),
    .o_valid (o_valid),
    .step    (step),
    .dir     (dir),
    .err     (err),
    .pos     (pos),
    .err_cnt (err_cnt)
  );

  gray_position_tracker #(.W(3), .PW(8), .EW(2)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .g       (g),
    .g_valid (g_valid),
    .b       (s_b),
    .o_valid (s_o_valid),
    .step    (s_step),
    .dir     (s_dir),
    .err     (s_err),
    .pos     (s_pos),
    .err_cnt (s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one sample, then idle; return on the falling edge after its
  // results are registered.
  task automatic send(input logic [2:0] gg);
    @(negedge clk);
    g       = gg;
    g_valid = 1'b1;
    @(negedge clk);
    g_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    g_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] cu_g [5];

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    g       = 3'b000;
    g_valid = 1'b0;
    cu_g    = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_b",       b,       0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_step",    step,    0);
    chk("rst_dir",     dir,     0);
    chk("rst_err",     err,     0);
    chk("rst_pos",     pos,     0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;

    // Count up, back-to-back: results of sample k appear two falling edges
    // after it is driven.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("cu_o_valid", o_valid, 1);
        chk("cu_b",       b,       i - 2);
        chk("cu_step",    step,    (i > 2) ? 1 : 0);
        chk("cu_pos",     pos,     i - 2);
        chk("cu_err",     err,     0);
      end
      if (i < 5) begin
        g       = cu_g[i];
        g_valid = 1'b1;
      end else begin
        g_valid = 1'b0;
      end
    end
    chk("cu_dir",     dir,     1);
    chk("cu_err_cnt", err_cnt, 0);
    @(negedge clk);
    chk("cu_gap_o_valid", o_valid, 0);
    chk("cu_gap_pos",     pos,     4);

    // Wrap both ways from pos=0
    do_reset();
    send(3'b100);
    chk("wr0_b",    b,    7);
    chk("wr0_step", step, 0);
    chk("wr0_pos",  pos,  0);
    send(3'b000);
    chk("wr1_b",    b,    0);
    chk("wr1_step", step, 1);
    chk("wr1_dir",  dir,  1);
    chk("wr1_pos",  pos,  1);
    send(3'b100);
    chk("wr2_b",    b,    7);
    chk("wr2_step", step, 1);
    chk("wr2_dir",  dir,  0);
    chk("wr2_pos",  pos,  0);
    send(3'b101);
    chk("wr3_b",    b,    6);
    chk("wr3_step", step, 1);
    chk("wr3_dir",  dir,  0);
    chk("wr3_pos",  pos,  8'hFF);

    // Illegal jump, resync, then legal step
    do_reset();
    send(3'b001);
    chk("ij0_b",    b,    1);
    chk("ij0_step", step, 0);
    send(3'b110);
    chk("ij1_o_valid", o_valid, 1);
    chk("ij1_err",     err,     1);
    chk("ij1_step",    step,    0);
    chk("ij1_pos",     pos,     0);
    chk("ij1_err_cnt", err_cnt, 1);
    chk("ij1_b",       b,       4);
    send(3'b111);
    chk("ij2_o_valid", o_valid, 1);
    chk("ij2_b",       b,       5);
    chk("ij2_step",    step,    0);
    chk("ij2_err",     err,     0);
    send(3'b101);
    chk("ij3_b",       b,       6);
    chk("ij3_step",    step,    1);
    chk("ij3_err",     err,     0);
    chk("ij3_pos",     pos,     1);
    chk("ij3_dir",     dir,     1);
    chk("ij3_err_cnt", err_cnt, 1);

    // Hold with gaps
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(3'b011);
      chk("hd_o_valid", o_valid, 1);
      chk("hd_step",    step,    0);
      chk("hd_err",     err,     0);
      chk("hd_b",       b,       2);
      chk("hd_pos",     pos,     0);
      @(negedge clk);
      chk("hd_gap_o_valid", o_valid, 0);
      chk("hd_gap_b",       b,       2);
      chk("hd_gap_pos",     pos,     0);
    end

    // Reset mid-stream
    do_reset();
    send(3'b000);
    send(3'b001);
    send(3'b011);
    send(3'b010);
    chk("rm_pre_pos", pos, 3);
    @(negedge clk);
    g       = 3'b110;
    g_valid = 1'b1;
    @(negedge clk);
    g_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_o_valid", o_valid, 0);
    chk("rm_step",    step,    0);
    chk("rm_b",       b,       0);
    chk("rm_pos",     pos,     0);
    chk("rm_dir",     dir,     0);
    @(negedge clk);
    chk("rm_late_o_valid", o_valid, 0);
    send(3'b010);
    chk("rm_post_o_valid", o_valid, 1);
    chk("rm_post_b",       b,       3);
    chk("rm_post_step",    step,    0);
    chk("rm_post_pos",     pos,     0);

    // Error counter saturation on the 2-bit instance
    do_reset();
    send(3'b000);
    for (int k = 0; k < 5; k++) begin
      send(3'b110);
      chk("sat_err",      s_err,     1);
      chk("sat_step",     s_step,    0);
      chk("sat_err_cnt",  s_err_cnt, (k < 3) ? k + 1 : 3);
      chk("sat_main_cnt", err_cnt,   k + 1);
      send(3'b000);
      chk("sat_rs_o_valid", s_o_valid, 1);
      chk("sat_rs_err",     s_err,     0);
      chk("sat_rs_step",    s_step,    0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_position_tracker.md
# gray_position_tracker

Downstream consumer of the gray-code encoder stage. Accepts a stream of W-bit gray codes, such as an absolute encoder or gray-coded counter output, and converts each one to binary. Each decoded code is classified against the previous one as hold, +1 step, −1 step or illegal jump. The block keeps a signed running position, a direction flag and a saturating error count, and sits between the gray source and the position/motion logic.

## Interface
Parameters:
- W, 3: gray/binary code width (≥2).
- PW, 8: position accumulator width (two's complement).
- EW, 8: error counter width.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock only.
- rst  in  1  synchronous, active-high reset.
- g  in  W  gray code input.
- g_valid  in  1  g is sampled on a clock edge only when this is 1.
- b  out  W  binary equivalent of the last decoded code.
- o_valid  out  1  one-cycle pulse: b/step/dir/err/pos reflect a new sample.
- step  out  1  one-cycle pulse: the sample was a legal ±1 move.
- dir  out  1  direction of the last legal step (1 = up, 0 = down); held between steps.
- err  out  1  one-cycle pulse: illegal jump detected.
- pos  out  PW  signed accumulated position.
- err_cnt  out  EW  count of illegal jumps; saturates at all-ones.

## Operation
- Stage 1 (input register): on an edge with g_valid=1, capture g into g_r and set v_r=1. Otherwise v_r=0.
- Stage 2 (decode), acting when v_r=1:
  - bn[W-1] = g_r[W-1]; bn[i] = bn[i+1] ^ g_r[i].
  - d = (bn − b_ref) mod 2^W, where b_ref is the stored previous binary.
- State machine IDLE / TRACK / RESYNC:
  - IDLE (after reset): the first valid sample loads b_ref=b=bn and pulses o_valid. No step, no err. Go to TRACK.
  - TRACK, d=0: o_valid pulse only; pos and dir unchanged.
  - TRACK, d=1: pos+1, dir=1, step pulse. Wrap-around (2^W−1 → 0) is a legal up step.
  - TRACK, d=2^W−1: pos−1, dir=0, step pulse. Wrap-around (0 → 2^W−1) is a legal down step.
  - TRACK, any other d: err pulse, err_cnt+1 (saturating), pos and dir unchanged, b=b_ref=bn. Go to RESYNC.
  - RESYNC: the next valid sample loads b_ref and b without a step or err and pulses o_valid. Go to TRACK. A further illegal jump cannot be flagged from RESYNC.
- pos wraps modulo 2^PW: 0x7F+1 → 0x80 and 0x00−1 → 0xFF for PW=8. There is no overflow flag.
- In every state, b_ref tracks b after each valid sample.

## Timing
- Latency: g_valid=1 sampled at edge E0, then b/pos/flags update at edge E1. o_valid, step and err are high for the single cycle following E1.
- Throughput: one sample per clock; back-to-back g_valid is supported with no stalls.
- Gaps in g_valid leave all outputs holding, with pulses low.
- Reset values: b=0, o_valid=0, step=0, dir=0, err=0, pos=0, err_cnt=0, state=IDLE, v_r=0, b_ref=0.
- Reset mid-stream: a sample captured in stage 1 when rst is asserted is discarded and produces no pulse. After rst deasserts, the first sample is treated as IDLE (no step).
- If rst and g_valid are high together, reset wins and the sample is dropped.
- step and err are mutually exclusive. o_valid is always high whenever step or err is high.

## Test plan
- Count up, W=3: g = 000,001,011,010,110 back-to-back. Required: b = 0,1,2,3,4; step pulses on samples 2–5; dir=1; pos=4; err_cnt=0.
- Wrap both ways: from b=7 (g=100) feed g=000, then 100, then 101. Required: pos +1, then −1, then −1 (net −1 = 0xFF from 0x00 start); dir=0 after the last step.
- Illegal jump: track to g=001 (b=1), feed g=110 (b=4). Required: err pulse, no step, pos unchanged, err_cnt=1, b=4. Then feed g=111 (b=5): no step, no err. Then feed g=101 (b=6): step, pos+1.
- Hold and gaps: repeat g=011 three times with idle cycles between. Required: three o_valid pulses, no step, pos constant, outputs stable during gaps.
- Reset mid-stream: at pos=3, assert rst in the cycle after g_valid. Required: no pulse from that sample; all outputs 0. The first post-reset sample g=010 gives b=3, no step, pos=0.
- Saturation: with EW=2, force 5 illegal jumps (alternating with resync samples). Required: err_cnt = 1,2,3,3,3 and err pulses all 5 times.
